aes_one_round: RTL and testbench

- Single registered AES-128 encryption round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, with the result captured in an output register.
- The datapath building block of an iterated/pipelined AES core. Instances chain back-to-back: state_out of one feeds state_in of the next.
- Round-key scheduling and the initial AddRoundKey happen outside this block.
- A parameter selects the final-round variant, which omits MixColumns.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_one_round_if.sv | 11 +
 rtl/aes_sbox.sv | 11 +
 rtl/aes_one_round.sv | 70 +++++++
 tb/tb_aes_one_round.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, forward S-box table and GF(2^8) helpers
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] state_t;

   localparam byte_t SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic byte_t xtime(input byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gf_mul2(input byte_t x);
      return xtime(x);
   endfunction

   function automatic byte_t gf_mul3(input byte_t x);
      return xtime(x) ^ x;
   endfunction

   // Byte 0 is the most significant byte; the state is column-major.
   function automatic int byte_idx(input int row, input int col);
      return row + 4 * col;
   endfunction

   function automatic byte_t get_byte(input state_t s, input int idx);
      return s[127 - 8 * idx -: 8];
   endfunction

endpackage

// File: rtl/aes_one_round_if.sv
// rtl/aes_one_round_if.sv - round datapath bus: input state, round key, registered result
interface aes_one_round_if;
   import aes_pkg::*;

   state_t state_in;
   state_t key;
   state_t state_out;

   modport master (output state_in, output key, input state_out);
   modport slave  (input state_in, input key, output state_out);
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box byte substitution
module aes_sbox
   import aes_pkg::*;
(
   input  byte_t in_i,
   output byte_t out_o
);

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_one_round.sv
// rtl/aes_one_round.sv - one registered AES-128 encryption round
// SubBytes -> ShiftRows -> MixColumns (skipped when LAST_ROUND) -> AddRoundKey -> register.
module aes_one_round
   import aes_pkg::*;
#(
   parameter int LAST_ROUND = 0
)(
   input  logic             clk,
   input  logic             rst_n,
   aes_one_round_if.slave   bus
);

   byte_t  sbox_in  [16];
   byte_t  sbox_out [16];
   state_t shifted;
   state_t mixed;
   state_t state_d;
   state_t state_q;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      assign sbox_in[i] = get_byte(bus.state_in, i);
      aes_sbox u_sbox (
         .in_i  (sbox_in[i]),
         .out_o (sbox_out[i])
      );
   end

   function automatic word_t mix_column(input word_t col);
      byte_t a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
              a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
              a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
              gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};
   endfunction

   // Row r of the output takes its byte from column (c + r) mod 4.
   always_comb begin
      shifted = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            shifted[127 - 8 * byte_idx(r, c) -: 8] = sbox_out[byte_idx(r, (c + r) % 4)];
         end
      end
   end

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         if (LAST_ROUND != 0) begin
            mixed[127 - 32 * c -: 32] = shifted[127 - 32 * c -: 32];
         end else begin
            mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
         end
      end
   end

   assign state_d = mixed ^ bus.key;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus.state_out = state_q;

endmodule

// File: tb/tb_aes_one_round.sv
// tb/tb_aes_one_round.sv - self-checking bench: normal/final round, back-to-back, reset, 9-stage chain
module tb_aes_one_round;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] n_in, n_key, l_in, l_key, ch_in, ch_key;
   int           n_checks = 0;
   int           n_errors = 0;
   logic [7:0]   sbox_ref [256];

   always #5 clk = ~clk;

   aes_one_round_if if_n ();
   aes_one_round_if if_l ();
   assign if_n.state_in = n_in;
   assign if_n.key      = n_key;
   assign if_l.state_in = l_in;
   assign if_l.key      = l_key;

   aes_one_round #(.LAST_ROUND(0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n));
   aes_one_round #(.LAST_ROUND(1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

   logic [127:0] chain_w [0:9];
   assign chain_w[0] = ch_in;
   for (genvar k = 0; k < 9; k++) begin : g_chain
      aes_one_round_if cif ();
      assign cif.state_in = chain_w[k];
      assign cif.key      = ch_key;
      assign chain_w[k+1] = cif.state_out;
      aes_one_round #(.LAST_ROUND(0)) u_stage (.clk(clk), .rst_n(rst_n), .bus(cif));
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %032h expected %032h", tag, got, exp);
      end
   endtask

   // Reference model: generic GF(2^8) multiply, S-box derived from inverse + affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input bit last);
      logic [7:0] a [16];
      logic [7:0] t [16];
      logic [7:0] m [16];
      logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
      logic [127:0] out;
      for (int i = 0; i < 16; i++) a[i] = sbox_ref[s[127 - 8*i -: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r + 4*c] = a[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            m[r + 4*c] = 8'h00;
            for (int j = 0; j < 4; j++) m[r + 4*c] ^= gmul(coef[(j - r + 4) % 4], t[j + 4*c]);
            if (last) m[r + 4*c] = t[r + 4*c];
         end
      for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = m[i] ^ k[127 - 8*i -: 8];
      return out;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [127:0] V2_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] V2_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] V2_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] V3_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
   localparam logic [127:0] V3_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] V3_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

   initial begin
      logic [127:0] exp_n, exp_l, exp_ch;
      build_sbox();

      // Reset held for two edges with arbitrary inputs
      rst_n = 1'b0;
      n_in = rnd128(); n_key = rnd128(); l_in = rnd128(); l_key = rnd128();
      ch_in = rnd128(); ch_key = rnd128();
      step();
      step();
      check("reset_n", if_n.state_out, '0);
      check("reset_l", if_l.state_out, '0);
      check("reset_chain", chain_w[9], '0);

      rst_n = 1'b1;
      n_in = '0; n_key = '0; l_in = '0; l_key = '0;
      step();
      check("zero_n", if_n.state_out, {16{8'h63}});
      check("zero_l", if_l.state_out, {16{8'h63}});

      n_in = V2_IN; n_key = V2_KEY; l_in = V3_IN; l_key = V3_KEY;
      step();
      check("fips_round1", if_n.state_out, V2_OUT);
      check("fips_round10", if_l.state_out, V3_OUT);

      // Back-to-back: vector 2 then the all-zero vector on consecutive cycles
      n_in = '0; n_key = '0;
      #3;
      check("b2b_hold", if_n.state_out, V2_OUT);
      @(negedge clk);
      check("b2b_second", if_n.state_out, {16{8'h63}});
      n_in = V2_IN; n_key = V2_KEY;
      step();
      check("b2b_third", if_n.state_out, V2_OUT);

      // Randomized stream against the model, one result per clock
      for (int it = 0; it < 120; it++) begin
         n_in = rnd128(); n_key = rnd128(); l_in = rnd128(); l_key = rnd128();
         if (it % 40 == 0) begin n_in = '1; l_in = '1; end
         exp_n = ref_round(n_in, n_key, 1'b0);
         exp_l = ref_round(l_in, l_key, 1'b1);
         step();
         check("rand_n", if_n.state_out, exp_n);
         check("rand_l", if_l.state_out, exp_l);
      end

      // Mid-stream reset for a single edge
      n_in = rnd128(); n_key = rnd128();
      rst_n = 1'b0;
      step();
      check("midreset_n", if_n.state_out, '0);
      check("midreset_l", if_l.state_out, '0);
      rst_n = 1'b1;
      n_in = rnd128(); n_key = rnd128(); l_in = rnd128(); l_key = rnd128();
      exp_n = ref_round(n_in, n_key, 1'b0);
      exp_l = ref_round(l_in, l_key, 1'b1);
      step();
      check("post_reset_n", if_n.state_out, exp_n);
      check("post_reset_l", if_l.state_out, exp_l);

      // Nine-stage chain with constant input and key, FIPS vector then random
      for (int v = 0; v < 2; v++) begin
         ch_in  = (v == 0) ? V2_IN  : rnd128();
         ch_key = (v == 0) ? V2_KEY : rnd128();
         exp_ch = ch_in;
         for (int s = 0; s < 9; s++) exp_ch = ref_round(exp_ch, ch_key, 1'b0);
         for (int cyc = 1; cyc <= 11; cyc++) begin
            step();
            if (cyc == 1 && v == 0) check("chain_stage1", chain_w[1], V2_OUT);
            if (cyc >= 9) check("chain_out", chain_w[9], exp_ch);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
